// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory responder: FSM states, access-size codes
// and the latched request record.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [2:0] CORE_WORD = 3'd0;
    localparam logic [2:0] CORE_BYTE = 3'd1;
    localparam logic [2:0] CORE_HALF = 3'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctype;
        logic        write;
    } mem_req_t;

endpackage

// File: rtl/mem_web_gen.sv
// Maps access size, byte offset and direction to the active-low per-byte
// write enables of the backing memory.
module mem_web_gen
    import cpu_mem_pkg::*;
(
    input  logic [2:0] ctype_i,
    input  logic [1:0] addr_i,
    input  logic       write_i,
    output logic [3:0] web_o
);

    // Unknown size codes fall back to a full-word store.
    always_comb begin
        web_o = 4'hF;
        if (write_i) begin
            case (ctype_i)
                CORE_BYTE: begin
                    case (addr_i)
                        2'd0:    web_o = 4'hE;
                        2'd1:    web_o = 4'hD;
                        2'd2:    web_o = 4'hB;
                        default: web_o = 4'h7;
                    endcase
                end
                CORE_HALF: web_o = addr_i[1] ? 4'h3 : 4'hC;
                default:   web_o = 4'h0;
            endcase
        end else begin
            web_o = 4'hF;
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Latches CPU instruction/data requests and serialises them (data first) onto
// one single-port memory. Optional CPU_MEM_PERF_CNT_EN adds stall/access counters.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       im_addr_i,
    input  logic              im_read_mem_i,
    input  logic [2:0]        im_core_type_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [31:0]       dm_datain_i,
    input  logic              dm_write_mem_i,
    input  logic              dm_read_mem_i,
    input  logic [2:0]        dm_core_type_i,
    output logic [31:0]       im_dataout_o,
    output logic [31:0]       dm_dataout_o,
    output logic              cpu_stall_o,
    output logic              mem_cs_o,
    output logic              mem_oe_o,
    output logic [3:0]        mem_web_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_datain_o,
    input  logic [31:0]       mem_dataout_i
`ifdef CPU_MEM_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       access_count_o
`endif
);

    localparam logic [3:0] WAIT_RELOAD = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dm_pend_q, dm_pend_d;
    logic              im_pend_q, im_pend_d;
    logic              serve_dm_q, serve_dm_d;
    mem_req_t          dm_req_q, dm_req_d;
    mem_req_t          im_req_q, im_req_d;
    logic [31:0]       im_dataout_q, im_dataout_d;
    logic [31:0]       dm_dataout_q, dm_dataout_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_oe_q, mem_oe_d;
    logic [3:0]        mem_web_q, mem_web_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_datain_q, mem_datain_d;

    logic              any_req_s;
    logic              issue_s;
    mem_req_t          issue_req_s;
    logic [3:0]        issue_web_s;
    logic              access_done_s;
    logic              unused_addr_s;

    assign any_req_s     = im_read_mem_i | dm_read_mem_i | dm_write_mem_i;
    assign access_done_s = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign unused_addr_s = ^issue_req_s.addr[31:ADDR_W+2];

    mem_web_gen u_web_gen (
        .ctype_i (issue_req_s.ctype),
        .addr_i  (issue_req_s.addr[1:0]),
        .write_i (issue_req_s.write),
        .web_o   (issue_web_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ACCESS only exits after the final pending access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req_s ? ACCESS : IDLE;
            ACCESS: begin
                if (access_done_s && !(serve_dm_q && im_pend_q)) begin
                    state_d = RESP;
                end else begin
                    state_d = ACCESS;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: latch requests, sequence accesses, capture reads.
    always_comb begin
        dm_req_d     = dm_req_q;
        im_req_d     = im_req_q;
        dm_pend_d    = dm_pend_q;
        im_pend_d    = im_pend_q;
        serve_dm_d   = serve_dm_q;
        cnt_d        = cnt_q;
        im_dataout_d = im_dataout_q;
        dm_dataout_d = dm_dataout_q;
        issue_s      = 1'b0;
        issue_req_s  = dm_req_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    dm_req_d.addr  = dm_addr_i;
                    dm_req_d.data  = dm_datain_i;
                    dm_req_d.ctype = dm_core_type_i;
                    dm_req_d.write = dm_write_mem_i;
                    im_req_d.addr  = im_addr_i;
                    im_req_d.data  = 32'd0;
                    im_req_d.ctype = im_core_type_i;
                    im_req_d.write = 1'b0;
                    dm_pend_d      = dm_read_mem_i | dm_write_mem_i;
                    im_pend_d      = im_read_mem_i;
                    serve_dm_d     = dm_pend_d;
                    cnt_d          = WAIT_RELOAD;
                    issue_s        = 1'b1;
                    issue_req_s    = dm_pend_d ? dm_req_d : im_req_d;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (serve_dm_q) begin
                        dm_pend_d = 1'b0;
                        if (!dm_req_q.write) begin
                            dm_dataout_d = mem_dataout_i;
                        end else begin
                            dm_dataout_d = dm_dataout_q;
                        end
                    end else begin
                        im_pend_d    = 1'b0;
                        im_dataout_d = mem_dataout_i;
                    end
                    if (serve_dm_q && im_pend_q) begin
                        serve_dm_d  = 1'b0;
                        cnt_d       = WAIT_RELOAD;
                        issue_s     = 1'b1;
                        issue_req_s = im_req_q;
                    end else begin
                        issue_s = 1'b0;
                    end
                end
            end
            RESP:    issue_s = 1'b0;
            default: issue_s = 1'b0;
        endcase
    end

    // Memory strobes: load on a new access, hold mid-access, idle otherwise.
    always_comb begin
        mem_cs_d     = 1'b0;
        mem_oe_d     = 1'b0;
        mem_web_d    = 4'hF;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        if (issue_s) begin
            mem_cs_d   = 1'b1;
            mem_oe_d   = ~issue_req_s.write;
            mem_web_d  = issue_web_s;
            mem_addr_d = issue_req_s.addr[ADDR_W+1:2];
            if (issue_req_s.write) begin
                mem_datain_d = issue_req_s.data;
            end else begin
                mem_datain_d = mem_datain_q;
            end
        end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
            mem_cs_d  = mem_cs_q;
            mem_oe_d  = mem_oe_q;
            mem_web_d = mem_web_q;
        end else begin
            mem_cs_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 4'd0;
            dm_pend_q    <= 1'b0;
            im_pend_q    <= 1'b0;
            serve_dm_q   <= 1'b0;
            dm_req_q     <= '0;
            im_req_q     <= '0;
            im_dataout_q <= 32'd0;
            dm_dataout_q <= 32'd0;
            mem_cs_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            mem_web_q    <= 4'hF;
            mem_addr_q   <= '0;
            mem_datain_q <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            dm_pend_q    <= dm_pend_d;
            im_pend_q    <= im_pend_d;
            serve_dm_q   <= serve_dm_d;
            dm_req_q     <= dm_req_d;
            im_req_q     <= im_req_d;
            im_dataout_q <= im_dataout_d;
            dm_dataout_q <= dm_dataout_d;
            mem_cs_q     <= mem_cs_d;
            mem_oe_q     <= mem_oe_d;
            mem_web_q    <= mem_web_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
        end
    end

    assign cpu_stall_o  = (state_q == ACCESS) || ((state_q == IDLE) && any_req_s);
    assign im_dataout_o = im_dataout_q;
    assign dm_dataout_o = dm_dataout_q;
    assign mem_cs_o     = mem_cs_q;
    assign mem_oe_o     = mem_oe_q;
    assign mem_web_o    = mem_web_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_datain_o = mem_datain_q;

`ifdef CPU_MEM_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] access_count_q;

    // Free-running performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            access_count_q <= 32'd0;
        end else begin
            if (cpu_stall_o) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (access_done_s) begin
                access_count_q <= access_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign access_count_o = access_count_q;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: a word-array reference model predicts
// stall length, per-cycle memory strobes and returned data for every request group.
module tb_cpu_mem_responder;

    localparam int ADDR_W = 14;
    localparam int W      = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       im_addr, dm_addr, dm_datain;
    logic              im_read_mem, dm_write_mem, dm_read_mem;
    logic [2:0]        im_core_type, dm_core_type;
    logic [31:0]       im_dataout, dm_dataout;
    logic              cpu_stall, mem_cs, mem_oe;
    logic [3:0]        mem_web;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_datain, mem_dataout;
`ifdef CPU_MEM_PERF_CNT_EN
    logic [31:0]       stall_cycles, access_count;
`endif

    cpu_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr_i      (im_addr),
        .im_read_mem_i  (im_read_mem),
        .im_core_type_i (im_core_type),
        .dm_addr_i      (dm_addr),
        .dm_datain_i    (dm_datain),
        .dm_write_mem_i (dm_write_mem),
        .dm_read_mem_i  (dm_read_mem),
        .dm_core_type_i (dm_core_type),
        .im_dataout_o   (im_dataout),
        .dm_dataout_o   (dm_dataout),
        .cpu_stall_o    (cpu_stall),
        .mem_cs_o       (mem_cs),
        .mem_oe_o       (mem_oe),
        .mem_web_o      (mem_web),
        .mem_addr_o     (mem_addr),
        .mem_datain_o   (mem_datain),
        .mem_dataout_i  (mem_dataout)
`ifdef CPU_MEM_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles),
        .access_count_o (access_count)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory: asynchronous read, byte-masked write while selected.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    assign mem_dataout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_cs && !mem_oe) begin
            for (int b = 0; b < 4; b++) begin
                if (!mem_web[b]) mem[mem_addr][8*b +: 8] <= mem_datain[8*b +: 8];
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard queues.
    int          exp_stall_q[$];
    logic [31:0] exp_im_q[$];
    logic [31:0] exp_dm_q[$];
    int          exp_tlen_q[$];
    logic [50:0] exp_trace_q[$];
    logic [50:0] obs_trace[$];
    logic [31:0] last_im = 32'd0;
    logic [31:0] last_dm = 32'd0;
    int          exp_stall_sum = 0;
    int          exp_acc_sum = 0;

    // Reference model of one request group; data side is served first.
    task automatic model_group(input logic imr, input logic dmr, input logic dmw,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] dd, input logic [2:0] dt);
        int n = 0;
        int widx;
        int lane;
        logic [3:0]  be;
        logic [31:0] mask;
        if (dmr || dmw) begin
            widx = int'((da >> 2) % DEPTH);
            if (dmw) begin
                lane = int'(da % 4);
                if (dt == 3'd1)      be = 4'(1 << lane);
                else if (dt == 3'd2) be = (lane >= 2) ? 4'b1100 : 4'b0011;
                else                 be = 4'b1111;
                mask = 32'd0;
                for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8*b));
                ref_mem[widx] = (ref_mem[widx] & ~mask) | (dd & mask);
                for (int c = 0; c <= W; c++) exp_trace_q.push_back({1'b0, ~be, 14'(widx), dd});
            end else begin
                last_dm = ref_mem[widx];
                for (int c = 0; c <= W; c++) exp_trace_q.push_back({1'b1, 4'hF, 14'(widx), 32'd0});
            end
            n++;
        end
        if (imr) begin
            widx = int'((ia >> 2) % DEPTH);
            last_im = ref_mem[widx];
            for (int c = 0; c <= W; c++) exp_trace_q.push_back({1'b1, 4'hF, 14'(widx), 32'd0});
            n++;
        end
        exp_stall_q.push_back(n * (W + 1) + 1);
        exp_im_q.push_back(last_im);
        exp_dm_q.push_back(last_dm);
        exp_tlen_q.push_back(n * (W + 1));
        exp_stall_sum += n * (W + 1) + 1;
        exp_acc_sum += n;
    endtask

    // Monitor: measures each stall window and checks the group on the first free cycle.
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
            obs_trace.delete();
        end else if (cpu_stall) begin
            stall_cnt++;
            if (mem_cs) obs_trace.push_back({mem_oe, mem_web, mem_addr, mem_oe ? 32'd0 : mem_datain});
        end else if (stall_cnt > 0) begin
            if (exp_stall_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_response: got stall of %0d cycles, expected none", stall_cnt);
            end else begin
                int tlen;
                int bad;
                logic [50:0] e;
                chk("stall_len", 64'(stall_cnt), 64'(exp_stall_q.pop_front()));
                chk("im_dataout", 64'(im_dataout), 64'(exp_im_q.pop_front()));
                chk("dm_dataout", 64'(dm_dataout), 64'(exp_dm_q.pop_front()));
                tlen = exp_tlen_q.pop_front();
                bad = (obs_trace.size() == tlen) ? 0 : 1000;
                for (int i = 0; i < tlen; i++) begin
                    e = exp_trace_q.pop_front();
                    if (i < obs_trace.size() && obs_trace[i] !== e) begin
                        bad++;
                        $display("  strobe cycle %0d: got %0h expected %0h", i, obs_trace[i], e);
                    end
                end
                chk("mem_strobe_trace", 64'(bad), 64'd0);
            end
            stall_cnt = 0;
            obs_trace.delete();
        end
    end

    // Drive one request group starting #1 after a posedge in IDLE.
    task automatic do_group(input logic imr, input logic dmr, input logic dmw,
                            input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] dd, input logic [2:0] dt);
        int k;
        model_group(imr, dmr, dmw, ia, da, dd, dt);
        im_read_mem  = imr;
        dm_read_mem  = dmr;
        dm_write_mem = dmw;
        im_addr      = ia;
        dm_addr      = da;
        dm_datain    = dd;
        dm_core_type = dt;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (!cpu_stall) break;
        end
        if (k >= 100) chk("stall_timeout", 64'(k), 64'd0);
        im_read_mem  = 1'b0;
        dm_read_mem  = 1'b0;
        dm_write_mem = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        logic [31:0] v;
        logic [2:0]  r;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
        mem[8] = 32'hCAFEBABE; ref_mem[8] = 32'hCAFEBABE;

        rst = 1'b1;
        im_addr = 32'd0; dm_addr = 32'd0; dm_datain = 32'd0;
        im_read_mem = 1'b0; dm_read_mem = 1'b0; dm_write_mem = 1'b0;
        im_core_type = 3'd0; dm_core_type = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_cs", 64'(mem_cs), 64'd0);
        chk("rst_oe", 64'(mem_oe), 64'd0);
        chk("rst_web", 64'(mem_web), 64'hF);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_datain", 64'(mem_datain), 64'd0);
        chk("rst_im_dataout", 64'(im_dataout), 64'd0);
        chk("rst_dm_dataout", 64'(dm_dataout), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_group(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 3'd0);
        do_group(1'b1, 1'b1, 1'b0, 32'h14, 32'h20, 32'h0, 3'd0);
`ifdef CPU_MEM_PERF_CNT_EN
        chk("perf_stall_after_two", 64'(stall_cycles), 64'd8);
        chk("perf_access_after_two", 64'(access_count), 64'd3);
`endif
        do_group(1'b0, 1'b0, 1'b1, 32'h0, 32'h23, 32'hAB000000, 3'd1);
        chk("byte_store_word8", 64'(mem[8]), 64'hABFEBABE);
        do_group(1'b0, 1'b0, 1'b1, 32'h0, 32'h22, 32'h12345678, 3'd2);
        chk("half_store_hi_word8", 64'(mem[8]), 64'h1234BABE);
        do_group(1'b0, 1'b0, 1'b1, 32'h0, 32'h21, 32'h9ABCDEF0, 3'd2);
        chk("half_store_lo_word8", 64'(mem[8]), 64'h1234DEF0);

        // Reset in the middle of a data read.
        dm_addr = 32'h40; dm_read_mem = 1'b1; im_read_mem = 1'b1; im_addr = 32'h44;
        @(posedge clk); #1;
        chk("pre_rst_cs", 64'(mem_cs), 64'd1);
        rst = 1'b1;
        dm_read_mem = 1'b0; im_read_mem = 1'b0;
        #1;
        chk("midrst_stall", 64'(cpu_stall), 64'd0);
        chk("midrst_cs", 64'(mem_cs), 64'd0);
        chk("midrst_web", 64'(mem_web), 64'hF);
        chk("midrst_im_dataout", 64'(im_dataout), 64'd0);
        chk("midrst_dm_dataout", 64'(dm_dataout), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_im = 32'd0; last_dm = 32'd0;
        exp_stall_sum = 0; exp_acc_sum = 0;
        @(posedge clk); #1;

        do_group(1'b1, 1'b1, 1'b0, 32'h44, 32'h40, 32'h0, 3'd0);
        for (int g = 0; g < 60; g++) begin
            r = 3'($urandom_range(1, 7));
            do_group(r[0], r[1], r[2],
                     ($urandom & 32'hFFFF0000) | (32'($urandom_range(0, 63)) << 2),
                     ($urandom & 32'hFFFF0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
                     $urandom, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("memory_image", 64'(bad), 64'd0);
        chk("scoreboard_drained", 64'(exp_stall_q.size()), 64'd0);
`ifdef CPU_MEM_PERF_CNT_EN
        chk("perf_stall_cycles", 64'(stall_cycles), 64'(exp_stall_sum));
        chk("perf_access_count", 64'(access_count), 64'(exp_acc_sum));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's instruction (im_*) and data (dm_*) request ports.
- Latches each request and arbitrates both ports onto one single-port, word-wide SRAM-style backing memory with a fixed access latency.
- Returns read data on im_dataout/dm_dataout and holds cpu_stall high until every latched request has completed.
- Sits between CPU and the memory macro at top level.

Parameters:
- ADDR_W, 14, word-address width driven to backing memory.
- WAIT_CYCLES, 1, extra memory wait states per access (0..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- im_addr  input  32  byte address of the instruction fetch.
- im_read_mem  input  1  instruction fetch request.
- im_core_type  input  3  access size for im (always 3'd0, word).
- dm_addr  input  32  byte address of the data access.
- dm_datain  input  32  store data, already lane-positioned by CPU.
- dm_write_mem  input  1  data store request.
- dm_read_mem  input  1  data load request.
- dm_core_type  input  3  access size: 3'd0 word, 3'd1 byte, 3'd2 half; others treated as word.
- im_dataout  output  32  fetched instruction word.
- dm_dataout  output  32  loaded full word; CPU performs lane extraction.
- cpu_stall  output  1  pipeline hold, combinational from state/request.
- mem_cs  output  1  memory chip select.
- mem_oe  output  1  memory output enable (reads).
- mem_web  output  4  per-byte write enable, active-low.
- mem_addr  output  ADDR_W  word address, addr[ADDR_W+1:2].
- mem_datain  output  32  write data to memory.
- mem_dataout  input  32  read data from memory, valid in last access cycle.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state IDLE; im_dataout and dm_dataout 0; mem_cs, mem_oe 0; mem_web 4'hF; mem_addr 0; mem_datain 0; pending flags clear.
- cpu_stall is 1 in ACCESS, 1 in IDLE when any request is asserted, and 0 otherwise.
- IDLE: if any of im_read_mem, dm_read_mem or dm_write_mem is high, latch addresses, data, types and pending flags, then go to ACCESS.
- Request inputs are ignored outside IDLE. CPU gates its requests low in the cycle after stall drops, so RESP never re-triggers.
- Arbitration: dm is served before im when both are pending (dm belongs to the older instruction).
- ACCESS:
  - Serve one pending access for WAIT_CYCLES+1 cycles; a 4-bit counter counts down.
  - mem_cs=1 throughout.
  - Read: mem_oe=1, mem_web=4'hF. Capture mem_dataout into the matching dataout register on the final cycle.
  - Write: mem_oe=0, mem_web derived from type and addr:
    - word: 4'h0.
    - half: addr[1]=0 gives 4'hC, addr[1]=1 gives 4'h3 (addr[0] ignored).
    - byte: bit addr[1:0] low.
  - Counter reloads on each access. After the last pending access, go to RESP.
- RESP: one cycle; cpu_stall=0; memory strobes idle; dataout registers held; next state IDLE.
- Stall length per request group: (number of accesses)*(WAIT_CYCLES+1)+1 cycles. Data is visible in the first non-stall cycle.
- Dataout registers change only on capture and persist across idle periods. A write does not modify dm_dataout.
- dm_read_mem and dm_write_mem both high: treated as write.
- Address bits above ADDR_W+1 are ignored (wrap).
- Reset mid-access: asynchronous return to reset values; the in-flight access is abandoned and a write may be partial.

Optional Feature:
- Macro: CPU_MEM_PERF_CNT_EN.
- When defined, adds output ports stall_cycles[31:0] and access_count[31:0].
  - stall_cycles increments every cycle cpu_stall=1.
  - access_count increments on every completed memory access.
  - Both reset to 0 and wrap at 2^32.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum (IDLE/ACCESS/RESP).
  - core_type constants CORE_WORD=3'd0, CORE_BYTE=3'd1, CORE_HALF=3'd2.
  - request struct {addr, data, type, write}.
- One sub-module: mem_web_gen, a combinational mapping of (type, addr[1:0], write) to mem_web.

Test Plan:
- WAIT_CYCLES=1, im_read_mem=1, im_addr=0x10, memory word4=0x00500093 -> cpu_stall high 3 cycles, mem_addr=4, im_dataout=0x00500093 on the first stall-low cycle.
- Simultaneous dm_read_mem at 0x20 (word8=0xCAFEBABE) and im fetch at 0x14 -> dm served first (mem_addr 8 then 5), stall 5 cycles, both dataouts valid together.
- Byte store, dm_core_type=1, dm_addr=0x23, dm_datain=0xAB000000 -> mem_web=4'h7, word8 byte3 becomes 0xAB, other bytes unchanged, dm_dataout unchanged.
- Half store at dm_addr=0x22 -> mem_web=4'h3; at 0x21 -> mem_web=4'hC (addr[0] ignored).
- Assert rst during ACCESS -> cpu_stall=0, mem_cs=0, mem_web=4'hF, dataouts 0 immediately; a new request after reset completes normally.
- With CPU_MEM_PERF_CNT_EN, run the second scenario -> stall_cycles=5, access_count=2.
